// File: rtl/rnd_hash_builder.sv
// Sequencer that runs HashWidth/2 RND rounds, shifts each 2-bit symbol into a hash and
// presents the finished hash on a valid/ready handshake, with a per-round stall watchdog.
module rnd_hash_builder #(
  parameter int unsigned SeedWidth = 6,
  parameter int unsigned HashWidth = 16,
  parameter int unsigned Timeout   = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [SeedWidth-1:0] seed_in_i,
  output logic                 busy_o,
  output logic                 start_rnd_o,
  output logic [SeedWidth-1:0] rnd_seed_o,
  input  logic                 done_rnd_i,
  input  logic [1:0]           x_in_i,
  output logic [HashWidth-1:0] hash_out_o,
  output logic                 hash_valid_o,
  input  logic                 hash_ready_i,
  output logic                 timeout_err_o
);

  localparam int unsigned Rounds = HashWidth / 2;
  localparam int unsigned RoundW = $clog2(Rounds) + 1;
  localparam int unsigned WdW    = $clog2(Timeout);

  typedef enum logic [1:0] {StIdle, StKick, StWait, StDone} state_e;

  state_e               state_q;
  logic [SeedWidth-1:0] seed_q;
  logic [RoundW-1:0]    round_q;
  logic [WdW-1:0]       wd_q;
  logic [HashWidth-1:0] hash_q;
  logic [HashWidth-1:0] hash_d;
  logic                 busy_q;
  logic                 start_rnd_q;
  logic                 hash_valid_q;
  logic                 err_q;

  // Shift form keeps HashWidth == 2 legal (no negative slice).
  always_comb begin
    hash_d = (hash_q << 2) | HashWidth'(x_in_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      seed_q       <= '0;
      round_q      <= '0;
      wd_q         <= '0;
      hash_q       <= '0;
      busy_q       <= 1'b0;
      start_rnd_q  <= 1'b0;
      hash_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      start_rnd_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            seed_q      <= seed_in_i;
            hash_q      <= '0;
            round_q     <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            start_rnd_q <= 1'b1;
            state_q     <= StKick;
          end
        end
        StKick: begin
          wd_q    <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // A done strobe on the watchdog's last cycle still completes the round.
          if (done_rnd_i) begin
            hash_q  <= hash_d;
            round_q <= round_q + RoundW'(1);
            if (round_q == RoundW'(Rounds - 1)) begin
              hash_valid_q <= 1'b1;
              state_q      <= StDone;
            end else begin
              start_rnd_q <= 1'b1;
              state_q     <= StKick;
            end
          end else if (wd_q == WdW'(Timeout - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            wd_q <= wd_q + WdW'(1);
          end
        end
        StDone: begin
          if (hash_ready_i) begin
            hash_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign start_rnd_o   = start_rnd_q;
  assign hash_valid_o  = hash_valid_q;
  assign timeout_err_o = err_q;
  // Only a completed hash is ever visible on the output.
  assign hash_out_o    = hash_valid_q ? hash_q : '0;
  assign rnd_seed_o    = (state_q == StIdle) ? '0 : (seed_q ^ SeedWidth'(round_q));

endmodule

// File: tb/tb_rnd_hash_builder.sv
// Directed/random bench for rnd_hash_builder with a stub RND driven from one initial block.
module tb_rnd_hash_builder;

  localparam int Rounds = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] seed_in;
  logic       busy;
  logic       start_rnd;
  logic [5:0] rnd_seed;
  logic       done_rnd;
  logic [1:0] x_in;
  logic [7:0] hash_out;
  logic       hash_valid;
  logic       hash_ready;
  logic       timeout_err;

  int n_checks = 0;
  int n_err    = 0;

  rnd_hash_builder #(
    .SeedWidth(6),
    .HashWidth(8),
    .Timeout  (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .seed_in_i    (seed_in),
    .busy_o       (busy),
    .start_rnd_o  (start_rnd),
    .rnd_seed_o   (rnd_seed),
    .done_rnd_i   (done_rnd),
    .x_in_i       (x_in),
    .hash_out_o   (hash_out),
    .hash_valid_o (hash_valid),
    .hash_ready_i (hash_ready),
    .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic err_exp);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " start_rnd"}, start_rnd, 1'b0);
    check({tag, " rnd_seed"}, rnd_seed, 6'h00);
    check({tag, " hash_out"}, hash_out, 8'h00);
    check({tag, " hash_valid"}, hash_valid, 1'b0);
    check({tag, " timeout_err"}, timeout_err, err_exp);
  endtask

  // One full request: symbol i arrives on WAIT cycle 'lat' of round i; model hash is the
  // symbols read as a base-4 number, first symbol most significant.
  task automatic run_txn(input logic [5:0] s, input logic [1:0] syms [Rounds], input int lat,
                         input bit noise, input int hold);
    logic [7:0] exp_hash;
    logic [5:0] exp_seed;
    exp_hash = 8'h00;
    for (int i = 0; i < Rounds; i++) exp_hash = exp_hash * 4 + 8'(syms[i]);
    seed_in = s;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    seed_in = 6'($urandom);
    check("start clears err", timeout_err, 1'b0);
    for (int r = 0; r < Rounds; r++) begin
      exp_seed = s ^ 6'(r);
      check("kick start_rnd", start_rnd, 1'b1);
      check("kick rnd_seed", rnd_seed, exp_seed);
      check("kick busy", busy, 1'b1);
      if (noise) begin
        done_rnd = 1'b1;
        x_in     = 2'($urandom);
      end
      tick();
      done_rnd = 1'b0;
      for (int w = 1; w <= lat; w++) begin
        if (w > 1) tick();
        check("wait start_rnd", start_rnd, 1'b0);
        check("wait rnd_seed", rnd_seed, exp_seed);
        check("wait hash_valid", hash_valid, 1'b0);
        if (w == lat) begin
          done_rnd = 1'b1;
          x_in     = syms[r];
        end
      end
      tick();
      done_rnd = 1'b0;
      x_in     = 2'($urandom);
    end
    check("done hash_valid", hash_valid, 1'b1);
    check("done hash_out", hash_out, exp_hash);
    check("done err", timeout_err, 1'b0);
    for (int h = 0; h < hold; h++) begin
      start = (h == 1);
      tick();
      start = 1'b0;
      check("hold hash_valid", hash_valid, 1'b1);
      check("hold hash_out", hash_out, exp_hash);
      check("hold busy", busy, 1'b1);
      check("hold start_rnd", start_rnd, 1'b0);
    end
    hash_ready = 1'b1;
    tick();
    hash_ready = 1'b0;
    check("post hash_valid", hash_valid, 1'b0);
    check("post busy", busy, 1'b0);
    tick();
    check("post idle start_rnd", start_rnd, 1'b0);
    check("post idle busy", busy, 1'b0);
  endtask

  initial begin
    logic [1:0] syms [Rounds];
    rst_n      = 1'b0;
    start      = 1'b0;
    seed_in    = 6'h00;
    done_rnd   = 1'b0;
    x_in       = 2'b00;
    hash_ready = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset", 1'b0);
    rst_n = 1'b1;
    tick();

    // Strobes while idle must not start anything.
    done_rnd = 1'b1;
    x_in     = 2'b11;
    tick();
    tick();
    done_rnd = 1'b0;
    check_idle_outputs("idle noise", 1'b0);

    // Nominal: symbols 10,01,11,00 give 8'h9C.
    syms = '{2'b10, 2'b01, 2'b11, 2'b00};
    run_txn(6'h07, syms, 3, 1'b0, 0);

    // Back-pressure with start pulsed during DONE.
    for (int i = 0; i < Rounds; i++) syms[i] = 2'($urandom);
    run_txn(6'($urandom), syms, 2, 1'b0, 5);

    // Timeout: no done_rnd at all.
    seed_in = 6'h15;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tick();
    for (int w = 1; w < 16; w++) tick();
    check("to wait16 busy", busy, 1'b1);
    check("to wait16 err", timeout_err, 1'b0);
    tick();
    check_idle_outputs("timeout", 1'b1);
    tick();
    check("timeout sticky", timeout_err, 1'b1);

    // Race: done on the 16th WAIT cycle, plus done noise during KICK.
    for (int i = 0; i < Rounds; i++) syms[i] = 2'($urandom);
    run_txn(6'($urandom), syms, 16, 1'b1, 1);

    // Reset during WAIT of round 2.
    seed_in = 6'h2A;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tick();
    tick();
    done_rnd = 1'b1;
    x_in     = 2'b01;
    tick();
    done_rnd = 1'b0;
    check("r2 kick start_rnd", start_rnd, 1'b1);
    tick();
    check("r2 wait rnd_seed", rnd_seed, 6'h2B);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < Rounds; i++) syms[i] = 2'($urandom);
    run_txn(6'h3F, syms, 3, 1'b0, 0);

    // Random requests.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < Rounds; i++) syms[i] = 2'($urandom);
      run_txn(6'($urandom), syms, int'($urandom_range(1, 16)), 1'($urandom),
              int'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
